// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage that feeds the immediate extender. It holds the PC,
// keeps at most one fetch outstanding to instruction memory, and registers the
// returned word together with its PC. It also supplies the extender's inputs,
// imm16 and the decoded ext_op.
//
// Handshake: imem_req is a one-cycle strobe with imem_addr valid in the same
// cycle. Memory answers with imem_rvalid/imem_rdata in a later cycle. A new
// request is never issued before the previous one has been answered.
// Downstream consumes the held instruction on any cycle where instr_valid=1 and
// stall=0. A redirect is a one-cycle pulse and takes priority over stall and
// rvalid.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   imem_req, imem_addr     fetch request strobe and word-aligned address
//   imem_rvalid, imem_rdata memory response
//   stall                   downstream cannot accept the held instruction
//   redirect, redirect_pc   taken branch/jump and its target
//   instr, instr_pc         held instruction and its address
//   pc_plus4                instr_pc + 4 (32-bit wrap)
//   instr_valid             instr/instr_pc hold a live instruction
//   imm16, ext_op           extender inputs
//   state_dbg               current FSM state (0 FETCH, 1 WAIT)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [15:0] imm16,
  output logic [1:0]  ext_op,
  output logic        state_dbg
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic        squash;

  logic slot_free;
  logic consume;
  logic load;
  logic drop;

  // The slot is free if it is empty or its occupant is consumed this cycle.
  assign slot_free = !instr_valid || !stall;
  assign consume   = instr_valid && !stall;
  assign load      = (state == S_WAIT) && imem_rvalid && !squash;
  assign drop      = (state == S_WAIT) && imem_rvalid && squash;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and request strobe
  // The strobe is decoded from registered state so a released stall issues
  // the request in that same cycle; a redirect suppresses it because the PC
  // is about to change. Gating with reset_n keeps the strobe low in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      S_FETCH: begin
        if (!redirect && slot_free) begin
          imem_req   = reset_n;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Any response ends the wait: loaded, squashed, or discarded by a
        // same-cycle redirect.
        if (imem_rvalid) begin
          state_next = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign imem_addr = pc;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Datapath: PC, squash flag and held instruction
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      squash      <= 1'b0;
      instr       <= NOP_WORD;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      // Remember to drop a response still in flight; if it arrives this very
      // cycle it is discarded here and nothing remains to squash.
      squash      <= (state == S_WAIT) && !imem_rvalid;
    end else begin
      if (load) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + 32'd4;
      end else if (consume) begin
        instr       <= NOP_WORD;
        instr_valid <= 1'b0;
      end
      if (drop) begin
        squash <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Extender inputs and PC+4
  // ---------------------------------------------------------------------------
  assign pc_plus4 = instr_pc + 32'd4;
  assign imm16    = instr[15:0];

  always_comb begin
    ext_op = 2'd1;
    case (instr[31:26])
      6'b001111: ext_op = 2'd2;                        // lui
      6'b001100, 6'b001101, 6'b001110: ext_op = 2'd0;  // andi, ori, xori
      default:   ext_op = 2'd1;
    endcase
  end

endmodule
